// File: rtl/rr_din_arbiter.sv
// Round-robin arbiter that locks one requester per burst onto a shared dout path.
// Grant follows req by one edge; beats forward combinationally; dout_ready=0 holds the burst in place.
module rr_din_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            grant,
    output logic [2:0]                    owner_id,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [2:0]           rr_ptr;
    logic [7:0]           beat_cnt;
    logic                 found;
    logic [2:0]           win_id;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 own_req, own_last, accept, release_now;
    logic [2:0]           ptr_nxt;

    // Two passes give the wrap-around search: indices >= rr_ptr first, then from 0.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        win_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(rr_ptr))) begin
                found     = 1'b1;
                win_id    = 3'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                win_id    = 3'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign own_req     = |(req & grant);
    assign own_last    = |(req_last & grant);
    assign accept      = (state == BUSY) && own_req && dout_ready;
    assign release_now = accept && (own_last || (beat_cnt + 8'd1 == 8'(MAX_BURST)));
    assign ptr_nxt     = (int'(owner_id) == NUM_REQ - 1) ? 3'd0 : owner_id + 3'd1;
    assign busy        = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)       state_nxt = BUSY;
            BUSY:    if (release_now) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dout_valid = (state == BUSY) && own_req;
        dout       = '0;
        if (dout_valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) dout = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant    <= win_oh;
                owner_id <= win_id;
                beat_cnt <= '0;
            end
            if (accept && beat_cnt != 8'(MAX_BURST)) beat_cnt <= beat_cnt + 8'd1;
            if (release_now) begin
                grant  <= '0;
                rr_ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rr_din_arbiter.sv
// Directed bench for rr_din_arbiter (MAX_BURST=4) with hand-computed expectations.
module tb_rr_din_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  grant;
    logic [2:0]  owner_id;
    logic        busy;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;

    int vectors = 0;
    int errors  = 0;

    rr_din_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .grant(grant), .owner_id(owner_id), .busy(busy), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        req_data[idx*8 +: 8] = val;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5] = '{2, 3, 0, 1, 2};

        rst = 1'b1; req = 4'b1111; req_data = 32'h0; req_last = 4'b0000; dout_ready = 1'b1;
        #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step();
        chk("rst_held_grant", 32'(grant), 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_owner", 32'(owner_id), 32'h0);
        req = 4'b0001; req_last = 4'b0001; set_data(0, 8'h5A);
        #1;
        chk("first_dout", 32'(dout), 32'h5A);
        step();
        chk("first_release", 32'(grant), 32'h0);
        chk("first_busy", 32'(busy), 32'h0);

        // Single three-beat burst from requester 1
        req = 4'b0010; req_last = 4'b0000; set_data(1, 8'h11);
        step();
        chk("sb_grant", 32'(grant), 32'h2);
        chk("sb_beat0", 32'(dout), 32'h11);
        chk("sb_valid0", 32'(dout_valid), 32'h1);
        step();
        set_data(1, 8'h22); #1;
        chk("sb_grant_mid", 32'(grant), 32'h2);
        chk("sb_beat1", 32'(dout), 32'h22);
        step();
        set_data(1, 8'h33); req_last = 4'b0010; #1;
        chk("sb_beat2", 32'(dout), 32'h33);
        step();
        chk("sb_release", 32'(grant), 32'h0);
        chk("sb_release_valid", 32'(dout_valid), 32'h0);
        req = 4'b0000;

        // Fairness: pointer sits at 2 after requester 1's burst
        req = 4'b1111; req_last = 4'b1111; req_data = 32'hA3A2A1A0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_grant", 32'(grant), 32'(1 << order[k]));
            chk("rr_dout", 32'(dout), 32'h0A0 + 32'(order[k]));
            step();
            chk("rr_gap_grant", 32'(grant), 32'h0);
            chk("rr_gap_valid", 32'(dout_valid), 32'h0);
        end
        req = 4'b0000;

        // Backpressure: pointer at 3, requester 2 wins by wrap
        req = 4'b0100; req_last = 4'b0100; set_data(2, 8'hA5); dout_ready = 1'b0;
        step();
        chk("bp_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 5; k++) begin
            chk("bp_dout", 32'(dout), 32'hA5);
            chk("bp_valid", 32'(dout_valid), 32'h1);
            chk("bp_cnt", 32'(dut.beat_cnt), 32'h0);
            if (k < 4) step();
        end
        step();
        chk("bp_hold_grant", 32'(grant), 32'h4);
        dout_ready = 1'b1;
        step();
        chk("bp_accept_release", 32'(grant), 32'h0);
        req = 4'b0000;

        // Forced release after MAX_BURST beats; req[3] rises once 0 owns the path
        req = 4'b0001; req_last = 4'b0000; req_data = 32'hC3000000;
        step();
        chk("fr_grant", 32'(grant), 32'h1);
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            set_data(0, 8'hB0 + 8'(k)); #1;
            chk("fr_owner_grant", 32'(grant), 32'h1);
            chk("fr_dout", 32'(dout), 32'hB0 + 32'(k));
            step();
        end
        chk("fr_released", 32'(grant), 32'h0);
        chk("fr_gap_valid", 32'(dout_valid), 32'h0);
        step();
        chk("fr_next_grant", 32'(grant), 32'h8);
        chk("fr_next_dout", 32'(dout), 32'hC3);
        req_last = 4'b1000;
        step();
        chk("fr_next_release", 32'(grant), 32'h0);
        req = 4'b0000; req_last = 4'b0000;

        // Async reset during the 2nd beat of a burst from requester 1
        req = 4'b0010; set_data(1, 8'hD1);
        step();
        chk("ar_grant", 32'(grant), 32'h2);
        step();
        set_data(1, 8'hD2); #1;
        chk("ar_beat2_valid", 32'(dout_valid), 32'h1);
        #1; rst = 1'b1; #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_valid", 32'(dout_valid), 32'h0);
        chk("ar_dout", 32'(dout), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        #1; rst = 1'b0;
        req = 4'b0100; set_data(2, 8'hE2);
        step();
        chk("ar_regrant", 32'(grant), 32'h4);
        chk("ar_owner", 32'(owner_id), 32'h2);

        // Owner drops req mid-burst, then resumes
        req = 4'b0000;
        step();
        chk("drop_busy", 32'(busy), 32'h1);
        chk("drop_valid", 32'(dout_valid), 32'h0);
        chk("drop_dout", 32'(dout), 32'h0);
        chk("drop_grant", 32'(grant), 32'h4);
        req = 4'b0100; #1;
        chk("resume_dout", 32'(dout), 32'hE2);
        chk("resume_valid", 32'(dout_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
